hazard3_pmp_fault_capture: RTL and testbench

Sits directly downstream of the PMP unit. Consumes its per-cycle fetch/load-store kill verdicts, qualifies them with request-valid strobes and prioritises simultaneous faults. Registers exactly one access fault (cause plus faulting address) and holds it on a valid/ready handshake to the trap logic. Also keeps a sticky overrun flag and a saturating fault counter for debug.

---
 rtl/hazard3_pmp_fault_capture_pkg.sv | 14 +
 rtl/hazard3_sat_counter.sv | 34 +++
 rtl/hazard3_pmp_fault_capture.sv | 108 ++++++++++
 tb/tb_hazard3_pmp_fault_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard3_pmp_fault_capture_pkg.sv
// Shared constants for the PMP fault capture block: mcause codes and FSM states.
// Cause codes must track the trap logic's mcause encoding.
package hazard3_pmp_fault_capture_pkg;

  localparam logic [3:0] CAUSE_INSTR_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pmp_fc_state_e;

endpackage

// File: rtl/hazard3_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module hazard3_sat_counter #(
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [W_CNT-1:0] count
);

  logic [W_CNT-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W_CNT'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W_CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard3_pmp_fault_capture.sv
// Captures one PMP access fault (cause + tval) from fetch/load-store verdicts
// and holds it on a valid/ready handshake to trap logic; debug overrun + count.
module hazard3_pmp_fault_capture
  import hazard3_pmp_fault_capture_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_CNT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic              i_kill,
  input  logic              d_req_valid,
  input  logic [W_ADDR-1:0] d_addr,
  input  logic              d_write,
  input  logic              d_kill,
  input  logic              flush,
  output logic              fault_valid,
  output logic [3:0]        fault_cause,
  output logic [W_ADDR-1:0] fault_tval,
  input  logic              fault_ready,
  output logic              busy,
  output logic              fault_overrun,
  output logic [W_CNT-1:0]  cnt,
  input  logic              cnt_clr
);

  pmp_fc_state_e     state_q, state_d;
  logic [3:0]        cause_q, cause_d;
  logic [W_ADDR-1:0] tval_q, tval_d;
  logic              overrun_q, overrun_d;

  logic              i_ev, d_ev, any_ev;
  logic [3:0]        new_cause;
  logic [W_ADDR-1:0] new_tval;

  assign i_ev   = i_req_valid & i_kill;
  assign d_ev   = d_req_valid & d_kill;
  assign any_ev = i_ev | d_ev;

  // Load/store wins a same-cycle tie: it belongs to the older instruction.
  assign new_cause = d_ev ? (d_write ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT)
                          : CAUSE_INSTR_FAULT;
  assign new_tval  = d_ev ? d_addr : i_addr;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    overrun_d = cnt_clr ? 1'b0 : overrun_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_ev) begin
            state_d = ST_PEND;
            cause_d = new_cause;
            tval_d  = new_tval;
          end
        end
        ST_PEND: begin
          if (fault_ready) begin
            if (any_ev) begin
              cause_d = new_cause;
              tval_d  = new_tval;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (any_ev) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cause_q   <= '0;
      tval_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      overrun_q <= overrun_d;
    end
  end

  hazard3_sat_counter #(.W_CNT(W_CNT)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (any_ev),
    .clr   (cnt_clr),
    .count (cnt)
  );

  assign fault_valid   = (state_q == ST_PEND);
  assign busy          = fault_valid;
  assign fault_cause   = cause_q;
  assign fault_tval    = tval_q;
  assign fault_overrun = overrun_q;

endmodule

// File: tb/tb_hazard3_pmp_fault_capture.sv
// Bench for hazard3_pmp_fault_capture: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the fault/counter rules.
module tb_hazard3_pmp_fault_capture;

  localparam int W_ADDR  = 32;
  localparam int W_CNT   = 4;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid, i_kill, d_req_valid, d_write, d_kill;
  logic [W_ADDR-1:0] i_addr, d_addr;
  logic              flush, fault_ready, cnt_clr;
  logic              fault_valid, busy, fault_overrun;
  logic [3:0]        fault_cause;
  logic [W_ADDR-1:0] fault_tval;
  logic [W_CNT-1:0]  cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_pend;
  int unsigned m_cause;
  longint unsigned m_tval;
  bit          m_over;
  int          m_cnt;

  always #5 clk = ~clk;

  hazard3_pmp_fault_capture #(.W_ADDR(W_ADDR), .W_CNT(W_CNT)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_addr        (i_addr),
    .i_kill        (i_kill),
    .d_req_valid   (d_req_valid),
    .d_addr        (d_addr),
    .d_write       (d_write),
    .d_kill        (d_kill),
    .flush         (flush),
    .fault_valid   (fault_valid),
    .fault_cause   (fault_cause),
    .fault_tval    (fault_tval),
    .fault_ready   (fault_ready),
    .busy          (busy),
    .fault_overrun (fault_overrun),
    .cnt           (cnt),
    .cnt_clr       (cnt_clr)
  );

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; i_req_valid = 0; i_kill = 0; i_addr = '0;
    d_req_valid = 0; d_kill = 0; d_write = 0; d_addr = '0;
    flush = 0; fault_ready = 0; cnt_clr = 0;
  endtask

  task automatic model_update();
    bit iev, dev, ev;
    iev = i_req_valid && i_kill;
    dev = d_req_valid && d_kill;
    ev  = iev || dev;
    if (rst) begin
      m_pend = 0; m_cause = 0; m_tval = 0; m_over = 0; m_cnt = 0;
      return;
    end
    if (cnt_clr) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < CNT_MAX) m_cnt++;
    if (cnt_clr) m_over = 0;
    if (!flush && m_pend && !fault_ready && ev) m_over = 1;
    if (flush) m_pend = 0;
    else if (ev && (!m_pend || fault_ready)) begin
      m_pend  = 1;
      m_cause = dev ? (d_write ? 7 : 5) : 1;
      m_tval  = dev ? d_addr : i_addr;
    end else if (m_pend && fault_ready) m_pend = 0;
  endtask

  // one clock: inputs held across the edge, model advanced, outputs checked
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("valid",   fault_valid,   m_pend);
    chk("busy",    busy,          m_pend);
    chk("cause",   fault_cause,   m_cause);
    chk("tval",    fault_tval,    m_tval);
    chk("overrun", fault_overrun, m_over);
    chk("cnt",     cnt,           m_cnt);
  endtask

  task automatic d_fault(input logic [W_ADDR-1:0] a, input logic wr);
    d_req_valid = 1; d_kill = 1; d_write = wr; d_addr = a;
  endtask

  task automatic i_fault(input logic [W_ADDR-1:0] a);
    i_req_valid = 1; i_kill = 1; i_addr = a;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    chk("rst_valid", fault_valid, 0);
    chk("rst_cnt", cnt, 0);
    idle_inputs();

    // load fault, held, then released by a ready pulse
    d_fault(32'h2000_0010, 0);
    step();
    idle_inputs();
    chk("ld_valid", fault_valid, 1);
    chk("ld_cause", fault_cause, 5);
    chk("ld_tval", fault_tval, 32'h2000_0010);
    chk("ld_cnt", cnt, 1);
    for (int k = 0; k < 5; k++) step();
    chk("ld_held", fault_valid, 1);
    fault_ready = 1;
    step();
    fault_ready = 0;
    chk("ld_release", fault_valid, 0);
    chk("ld_tval_kept", fault_tval, 32'h2000_0010);

    // clear counter, then simultaneous fetch + store
    cnt_clr = 1; step(); cnt_clr = 0;
    chk("clr_cnt", cnt, 0);
    i_fault(32'h100); d_fault(32'h3000_0000, 1);
    step();
    idle_inputs();
    chk("st_cause", fault_cause, 7);
    chk("st_tval", fault_tval, 32'h3000_0000);
    chk("st_cnt_once", cnt, 1);
    fault_ready = 1; step(); fault_ready = 0;

    // back-to-back: fetch fault pending, ready with new load fault
    i_fault(32'h0000_8000); step(); idle_inputs();
    chk("if_cause", fault_cause, 1);
    fault_ready = 1; d_fault(32'h44, 0); step(); idle_inputs();
    chk("b2b_valid", fault_valid, 1);
    chk("b2b_cause", fault_cause, 5);
    chk("b2b_tval", fault_tval, 32'h44);
    chk("b2b_over", fault_overrun, 0);

    // overrun, flush, clear
    i_fault(32'h0000_9000); step(); idle_inputs();
    chk("ov_cause", fault_cause, 5);
    chk("ov_tval", fault_tval, 32'h44);
    chk("ov_flag", fault_overrun, 1);
    chk("ov_cnt", cnt, 4);
    flush = 1; d_fault(32'h55, 1); step(); idle_inputs();
    chk("fl_valid", fault_valid, 0);
    chk("fl_cnt", cnt, 5);
    cnt_clr = 1; step(); cnt_clr = 0;
    chk("clr2_cnt", cnt, 0);
    chk("clr2_over", fault_overrun, 0);

    // kill without valid is ignored
    i_kill = 1; d_kill = 1; step(); idle_inputs();
    chk("nq_valid", fault_valid, 0);
    chk("nq_cnt", cnt, 0);

    // saturation
    fault_ready = 1;
    for (int k = 0; k < 20; k++) begin
      d_fault(32'h1000 + k * 4, k[0]);
      step();
    end
    idle_inputs();
    chk("sat_cnt", cnt, CNT_MAX);
    fault_ready = 1; step(); fault_ready = 0;

    // clear together with an event
    cnt_clr = 1; i_fault(32'h200); step(); idle_inputs();
    chk("clr_ev_cnt", cnt, 1);

    // reset mid-PEND with overrun set, then capture right after
    d_fault(32'h77, 0); step(); idle_inputs();
    chk("pre_rst_over", fault_overrun, 1);
    rst = 1; step(); rst = 0;
    chk("mr_valid", fault_valid, 0);
    chk("mr_cause", fault_cause, 0);
    chk("mr_tval", fault_tval, 0);
    chk("mr_over", fault_overrun, 0);
    chk("mr_cnt", cnt, 0);
    d_fault(32'hABC0, 1); step(); idle_inputs();
    chk("pr_valid", fault_valid, 1);
    chk("pr_cause", fault_cause, 7);
    chk("pr_tval", fault_tval, 32'hABC0);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 99) == 0);
      i_req_valid = $urandom_range(0, 1);
      i_kill      = ($urandom_range(0, 2) == 0);
      i_addr      = $urandom;
      d_req_valid = $urandom_range(0, 1);
      d_kill      = ($urandom_range(0, 2) == 0);
      d_write     = $urandom_range(0, 1);
      d_addr      = $urandom;
      flush       = ($urandom_range(0, 9) == 0);
      fault_ready = ($urandom_range(0, 2) == 0);
      cnt_clr     = ($urandom_range(0, 24) == 0);
      step();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
